// File: rtl/debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_pkg
// Description : Shared helpers for the multi-channel switch debouncer:
//               microsecond tick divisor, counter/prescaler widths and a
//               parameter sanity check used at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package debouncer_pkg;

    localparam int unsigned c_HZ_PER_MHZ = 1_000_000;

    // Clock cycles per microsecond tick.
    function automatic int unsigned tick_div(input int unsigned clk_freq);
        return clk_freq / c_HZ_PER_MHZ;
    endfunction

    // Width of a per-channel stable-time counter (counts 0..stable_time-1).
    function automatic int unsigned cnt_width(input int unsigned stable_time);
        return (stable_time < 1) ? 1 : $clog2(stable_time + 1);
    endfunction

    // Width of the shared prescaler; never below 1 bit even when div == 1.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

    // Legal configuration: whole MHz clock, non-zero stable time, 1..32 channels.
    function automatic bit params_ok(input int unsigned clk_freq,
                                     input int unsigned stable_time,
                                     input int unsigned num_ch);
        return ((clk_freq % c_HZ_PER_MHZ) == 0) && (clk_freq >= c_HZ_PER_MHZ) &&
               (stable_time >= 1) && (num_ch >= 1) && (num_ch <= 32);
    endfunction

endpackage : debouncer_pkg
`default_nettype wire

// File: rtl/debouncer_chan.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_chan
// Description : One debounce channel: two-flop synchroniser, stable-time
//               counter advanced on the shared microsecond tick, debounced
//               level register and one-cycle rise/fall pulses.
// Ports       : clk_i   - system clock
//               rst_ni  - asynchronous active-low reset
//               tick_i  - one-cycle microsecond tick from the shared prescaler
//               sw_i    - raw asynchronous switch input
//               level_o - debounced level
//               rise_o  - one-cycle pulse on debounced 0->1
//               fall_o  - one-cycle pulse on debounced 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_chan
    import debouncer_pkg::*;
#(
    parameter int unsigned STABLE_TIME = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned          c_CNT_W   = cnt_width(STABLE_TIME);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(STABLE_TIME - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;

    logic               w_mismatch;
    logic               w_expire;

    assign w_mismatch = r_sync ^ r_level;
    // Final tick of an uninterrupted mismatch: the new level is accepted.
    assign w_expire   = w_mismatch & tick_i & (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= sw_i;
            r_sync <= r_meta;
        end
    end

    // Any cycle of agreement restarts the count, so a glitch never
    // accumulates across separate mismatch windows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_expire &  r_sync;
            r_fall <= w_expire & ~r_sync;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (tick_i) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_cnt   <= '0;
                    r_level <= r_sync;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

endmodule : debouncer_chan
`default_nettype wire

// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_debouncer
// Description : NumCh independent switch debouncers sharing one microsecond
//               prescaler. Optional sticky event/interrupt logic is built when
//               the macro MULTI_DEBOUNCER_IRQ_EN is defined.
// Ports       : clk_i      - system clock
//               rst_ni     - asynchronous active-low reset
//               sw_i       - raw switch inputs, one bit per channel
//               db_level_o - debounced levels
//               db_rise_o  - one-cycle rise pulses
//               db_fall_o  - one-cycle fall pulses
//               evt_clr_i  - per-channel event clear     (IRQ build only)
//               evt_o      - sticky per-channel events   (IRQ build only)
//               irq_o      - registered OR of evt_o      (IRQ build only)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_debouncer
    import debouncer_pkg::*;
#(
    parameter int unsigned NumCh      = 4,
    parameter int unsigned ClkFreq    = 100_000_000,
    parameter int unsigned StableTime = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumCh-1:0] sw_i,
`ifdef MULTI_DEBOUNCER_IRQ_EN
    input  logic [NumCh-1:0] evt_clr_i,
    output logic [NumCh-1:0] evt_o,
    output logic             irq_o,
`endif
    output logic [NumCh-1:0] db_level_o,
    output logic [NumCh-1:0] db_rise_o,
    output logic [NumCh-1:0] db_fall_o
);

    localparam int unsigned        c_DIV       = tick_div(ClkFreq);
    localparam int unsigned        c_PRESC_W   = presc_width(c_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(c_DIV - 1);

    if (!params_ok(ClkFreq, StableTime, NumCh)) begin : g_param_check
        $error("multi_debouncer: illegal ClkFreq/StableTime/NumCh configuration");
    end

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;

    // Free-running from reset; the first tick lands c_DIV cycles after release.
    assign w_tick = (r_presc == c_PRESC_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar n = 0; n < NumCh; n++) begin : g_chan
        debouncer_chan #(
            .STABLE_TIME (StableTime)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .tick_i  (w_tick),
            .sw_i    (sw_i[n]),
            .level_o (db_level_o[n]),
            .rise_o  (db_rise_o[n]),
            .fall_o  (db_fall_o[n])
        );
    end

`ifdef MULTI_DEBOUNCER_IRQ_EN
    logic [NumCh-1:0] r_evt;
    logic             r_irq;

    // Set term is OR-ed after the clear so a same-cycle edge is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt <= '0;
            r_irq <= 1'b0;
        end else begin
            r_evt <= (r_evt & ~evt_clr_i) | db_rise_o | db_fall_o;
            r_irq <= |r_evt;
        end
    end

    assign evt_o = r_evt;
    assign irq_o = r_irq;
`endif

endmodule : multi_debouncer
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debouncer
// Description : Self-checking bench for multi_debouncer (4 channels, 4 MHz,
//               3 us stable time). A behavioural model tracks how long each
//               synchronised input has disagreed with the debounced level and
//               accepts the new level on a tick once that disagreement spans
//               the last StableTime ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;

    localparam int N  = 4;
    localparam int CF = 4_000_000;
    localparam int ST = 3;
    localparam int D  = CF / 1_000_000;
    // Uninterrupted disagreement (in cycles) that spans StableTime ticks.
    localparam int W  = (ST - 1) * D + 1;

    logic         clk    = 1'b0;
    logic         rst_ni = 1'b1;
    logic [N-1:0] sw_i   = '0;
    logic [N-1:0] db_level_o;
    logic [N-1:0] db_rise_o;
    logic [N-1:0] db_fall_o;
`ifdef MULTI_DEBOUNCER_IRQ_EN
    logic [N-1:0] evt_clr_i = '0;
    logic [N-1:0] evt_o;
    logic         irq_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_debouncer #(
        .NumCh      (N),
        .ClkFreq    (CF),
        .StableTime (ST)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .sw_i       (sw_i),
`ifdef MULTI_DEBOUNCER_IRQ_EN
        .evt_clr_i  (evt_clr_i),
        .evt_o      (evt_o),
        .irq_o      (irq_o),
`endif
        .db_level_o (db_level_o),
        .db_rise_o  (db_rise_o),
        .db_fall_o  (db_fall_o)
    );

    // ---------------- reference model ----------------
    logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    int           m_edges;
    int           m_run [N];

    always @(posedge clk or negedge rst_ni) begin : model
        bit           tick;
        int           run;
        logic [N-1:0] nl, nr, nf;
        if (!rst_ni) begin
            m_s1    <= '0;
            m_s2    <= '0;
            m_lvl   <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            m_edges <= 0;
            for (int n = 0; n < N; n++) m_run[n] <= 0;
        end else begin
            tick = ((m_edges % D) == (D - 1));
            nl = m_lvl;
            nr = '0;
            nf = '0;
            for (int n = 0; n < N; n++) begin
                run = (m_s2[n] != m_lvl[n]) ? m_run[n] + 1 : 0;
                if (tick && run >= W) begin
                    nl[n] = m_s2[n];
                    nr[n] = m_s2[n];
                    nf[n] = ~m_s2[n];
                    run   = 0;
                end
                m_run[n] <= run;
            end
            m_lvl   <= nl;
            m_rise  <= nr;
            m_fall  <= nf;
            m_s2    <= m_s1;
            m_s1    <= sw_i;
            m_edges <= m_edges + 1;
        end
    end

    // ---------------- pulse counters ----------------
    int rise_cnt [N] = '{default: 0};
    int fall_cnt [N] = '{default: 0};

    always @(negedge clk) begin
        for (int n = 0; n < N; n++) begin
            rise_cnt[n] <= rise_cnt[n] + int'(db_rise_o[n]);
            fall_cnt[n] <= fall_cnt[n] + int'(db_fall_o[n]);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        sw_i   = '0;
`ifdef MULTI_DEBOUNCER_IRQ_EN
        evt_clr_i = '0;
`endif
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst_ni = 1'b0;
        sw_i = '1;
        #2;
        checks++;
        if ({db_level_o, db_rise_o, db_fall_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %b, expected 0", {db_level_o, db_rise_o, db_fall_o});
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({db_level_o, db_rise_o, db_fall_o} !== '0) begin
            errors++;
            $display("FAIL reset_held: got %b, expected 0", {db_level_o, db_rise_o, db_fall_o});
        end
`ifdef MULTI_DEBOUNCER_IRQ_EN
        checks++;
        if ({evt_o, irq_o} !== '0) begin
            errors++;
            $display("FAIL reset_irq: got %b, expected 0", {evt_o, irq_o});
        end
`endif
        sw_i   = '0;
        rst_ni = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (db_level_o !== '0) begin
            errors++;
            $display("FAIL reset_idle_level: got %b, expected 0000", db_level_o);
        end
    endtask

    task automatic test_rise();
        int  lat = 0;
        bit  seen = 0;
        int  rb [N];
        for (int n = 0; n < N; n++) rb[n] = rise_cnt[n];
        @(negedge clk);
        sw_i[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (db_level_o[0]) begin
                seen = 1;
                lat  = k;
                break;
            end
        end
        checks++;
        if (!seen || lat < 10 || lat > 14) begin
            errors++;
            $display("FAIL rise_latency: got %0d (seen=%0d), expected 10..14", lat, seen);
        end
        checks++;
        if (db_rise_o !== 4'b0001 || db_level_o !== m_lvl) begin
            errors++;
            $display("FAIL rise_pulse: rise=%b level=%b, expected rise=0001 level=%b",
                     db_rise_o, db_level_o, m_lvl);
        end
        @(negedge clk);
        checks++;
        if (db_rise_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_width: got %b, expected 0 one cycle later", db_rise_o[0]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rise_cnt[0] - rb[0] != 1 || db_level_o !== 4'b0001 ||
            rise_cnt[1] != rb[1] || rise_cnt[2] != rb[2] || rise_cnt[3] != rb[3]) begin
            errors++;
            $display("FAIL rise_isolation: level=%b rise0 pulses=%0d, expected level=0001 and one pulse",
                     db_level_o, rise_cnt[0] - rb[0]);
        end
    endtask

    task automatic test_glitch();
        int rb = rise_cnt[1];
        int fb = fall_cnt[1];
        @(negedge clk);
        sw_i[1] = 1'b1;
        repeat (6) @(negedge clk);
        sw_i[1] = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (db_level_o[1] !== 1'b0 || rise_cnt[1] != rb || fall_cnt[1] != fb) begin
            errors++;
            $display("FAIL glitch_reject: level=%b pulses=%0d, expected level=0 pulses=0",
                     db_level_o[1], (rise_cnt[1] - rb) + (fall_cnt[1] - fb));
        end
    endtask

    task automatic test_fall();
        bit seen = 0;
        int fb;
        @(negedge clk);
        sw_i[2] = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = db_level_o[2];
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fall_setup: level=%b, expected 1 within 30 cycles", db_level_o[2]);
        end
        repeat (3) @(negedge clk);
        fb = fall_cnt[2];
        sw_i[2] = 1'b0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = !db_level_o[2];
        end
        checks++;
        if (!seen || db_fall_o[2] !== 1'b1 || db_rise_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL fall_pulse: level=%b fall=%b rise=%b, expected level=0 fall=1 rise=0",
                     db_level_o[2], db_fall_o[2], db_rise_o[2]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (fall_cnt[2] - fb != 1 || db_level_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL fall_once: pulses=%0d level=%b, expected 1 pulse level=0",
                     fall_cnt[2] - fb, db_level_o[2]);
        end
    endtask

    task automatic test_all_rise();
        bit seen = 0;
        do_reset();
        repeat (5) @(negedge clk);
        sw_i = 4'b1111;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (db_rise_o != '0);
        end
        checks++;
        if (!seen || db_rise_o !== 4'b1111 || db_level_o !== 4'b1111) begin
            errors++;
            $display("FAIL all_rise: rise=%b level=%b, expected 1111 1111", db_rise_o, db_level_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int lat = 0;
        int rb;
        do_reset();
        repeat (5) @(negedge clk);
        rb = rise_cnt[3];
        sw_i[3] = 1'b1;
        // Eight consecutive disagreeing cycles always contain exactly two ticks.
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (m_run[3] == 2 * D);
        end
        checks++;
        if (!seen || db_level_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_setup: reached=%0d level=%b, expected reached=1 level=0",
                     seen, db_level_o[3]);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({db_level_o, db_rise_o, db_fall_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, expected 0", {db_level_o, db_rise_o, db_fall_o});
        end
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        seen = 0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (db_level_o[3]) begin
                seen = 1;
                lat  = k;
            end
        end
        checks++;
        if (!seen || lat < 10 || lat > 14) begin
            errors++;
            $display("FAIL midreset_restart: latency=%0d (seen=%0d), expected 10..14", lat, seen);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rise_cnt[3] - rb != 1) begin
            errors++;
            $display("FAIL midreset_pulses: got %0d rise pulses, expected 1", rise_cnt[3] - rb);
        end
    endtask

    task automatic test_random();
        int flips = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if ({db_level_o, db_rise_o, db_fall_o} !== {m_lvl, m_rise, m_fall}) begin
                errors++;
                $display("FAIL random_model cycle %0d: got lvl=%b rise=%b fall=%b, expected lvl=%b rise=%b fall=%b",
                         i, db_level_o, db_rise_o, db_fall_o, m_lvl, m_rise, m_fall);
            end
            if ((db_rise_o & db_fall_o) != '0) begin
                errors++;
                $display("FAIL random_exclusive cycle %0d: rise=%b fall=%b, expected disjoint",
                         i, db_rise_o, db_fall_o);
            end
            flips += $countones(m_rise | m_fall);
            // Long holds first, then a glitchy phase.
            for (int n = 0; n < N; n++) begin
                if ($urandom_range((i < 300) ? 13 : 3) == 0) sw_i[n] = ~sw_i[n];
            end
        end
        checks++;
        if (flips == 0) begin
            errors++;
            $display("FAIL random_activity: got %0d level changes, expected > 0", flips);
        end
    endtask

`ifdef MULTI_DEBOUNCER_IRQ_EN
    task automatic test_irq();
        bit seen = 0;
        do_reset();
        repeat (5) @(negedge clk);
        sw_i[0] = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = db_rise_o[0];
        end
        // Clear coincides with the rise pulse: the set must win.
        evt_clr_i[0] = 1'b1;
        @(negedge clk);
        evt_clr_i[0] = 1'b0;
        checks++;
        if (!seen || evt_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL irq_evt_set: seen=%0d evt=%b, expected evt=1", seen, evt_o[0]);
        end
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_assert: got %b, expected 1", irq_o);
        end
        evt_clr_i[0] = 1'b1;
        @(negedge clk);
        evt_clr_i[0] = 1'b0;
        checks++;
        if (evt_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL irq_evt_clear: got %b, expected 0", evt_o[0]);
        end
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_deassert: got %b, expected 0", irq_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_all_rise();
        test_reset_mid();
        test_random();
`ifdef MULTI_DEBOUNCER_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_multi_debouncer
`default_nettype wire

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter NumCh, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter ClkFreq, default 100_000_000: clock frequency in Hz, an integer multiple of 1_000_000.
REQ-003 Parameter StableTime, default 10: required stable time in microseconds, at least 1.
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 sw_i  input  NumCh  raw asynchronous switch inputs, one bit per channel.
REQ-007 db_level_o  output  NumCh  debounced level per channel.
REQ-008 db_rise_o  output  NumCh  one-cycle pulse when a channel's debounced level goes 0->1.
REQ-009 db_fall_o  output  NumCh  one-cycle pulse when a channel's debounced level goes 1->0.

Function
REQ-010 Each channel synchronises sw_i[n] through two flip-flops; sync[n] is the second flip-flop's output.
REQ-011 One shared prescaler asserts us_tick for one cycle every ClkFreq/1_000_000 cycles, free-running from reset.
REQ-012 Each channel has a counter cnt[n] of width $clog2(StableTime+1).
REQ-013 Any cycle with sync[n] == db_level_o[n]: cnt[n] <= 0, regardless of us_tick.
REQ-014 us_tick cycle with sync[n] != db_level_o[n] and cnt[n] < StableTime-1: cnt[n] increments by 1.
REQ-015 us_tick cycle with sync[n] != db_level_o[n] and cnt[n] == StableTime-1: db_level_o[n] <= sync[n] and cnt[n] <= 0.
REQ-016 In the same cycle as REQ-015, the matching pulse fires on the next edge: db_rise_o[n] if the new level is 1, db_fall_o[n] if it is 0; the pulse lasts exactly one cycle.
REQ-017 db_rise_o[n] and db_fall_o[n] are never both high; a channel emits at most one pulse per us_tick period.
REQ-018 A glitch shorter than StableTime ticks never changes db_level_o; any mismatch gap restarts the count from 0.
REQ-019 Latency from a sw_i edge to the db_level_o change is 2 sync cycles plus StableTime ticks, with up to one tick period of jitter.
REQ-020 Channels are fully independent; pulses on several channels in the same cycle are legal.
REQ-021 The counter never exceeds StableTime-1 and never wraps.

Reset
REQ-022 While rst_ni is low: sync flip-flops, cnt, prescaler, db_level_o, db_rise_o and db_fall_o are all 0, asynchronously.
REQ-023 After rst_ni deasserts, the first us_tick occurs ClkFreq/1_000_000 cycles later.
REQ-024 A channel held at 1 through reset produces a single db_rise_o after the debounce time.
REQ-025 Reset asserted mid-count discards all partial counts; no pulse is emitted during or because of reset.

Configuration
REQ-026 With macro MULTI_DEBOUNCER_IRQ_EN defined, the block adds input evt_clr_i (NumCh), output evt_o (NumCh) and output irq_o (1).
REQ-027 With the macro defined, evt_o[n] is a sticky bit set by db_rise_o[n] or db_fall_o[n] and cleared by evt_clr_i[n]; set wins when both occur in the same cycle.
REQ-028 With the macro defined, irq_o is a registered OR of evt_o, and evt_o resets to 0.
REQ-029 Without the macro, those ports and that logic are absent and all other behaviour is unchanged.

Structure
REQ-030 Package debouncer_pkg holds the us-tick divisor function, the counter-width function and an elaboration check that ClkFreq % 1_000_000 == 0 and StableTime >= 1.
REQ-031 Sub-module debouncer_chan implements one channel (sync, counter, level, pulses) and is instantiated NumCh times under a generate loop; the prescaler stays in the top level.

Verification (NumCh=4, ClkFreq=4_000_000, StableTime=3, so 4 cycles per tick)
REQ-032 Bench covers: sw_i[0] 0->1 held -> db_level_o[0]=1 after 10..14 cycles, db_rise_o[0] high for exactly 1 cycle, other channels stay 0.
REQ-033 Bench covers: sw_i[1] high for 6 cycles then low -> db_level_o[1] stays 0 and no pulse occurs.
REQ-034 Bench covers: channel 2 debounced at 1, then sw_i[2]=0 held -> db_fall_o[2] pulses once and db_level_o[2]=0.
REQ-035 Bench covers: sw_i=4'b1111 in the same cycle -> all four db_rise_o bits pulse in the same cycle.
REQ-036 Bench covers: rst_ni pulsed low while cnt[3]=2 -> db_level_o[3]=0, no pulse, and the count restarts from 0.
REQ-037 Bench covers, with MULTI_DEBOUNCER_IRQ_EN: a rise on ch0 -> evt_o[0]=1 and irq_o=1 one cycle later; evt_clr_i[0] -> evt_o[0]=0 and irq_o=0.
